// File: rtl/lenet_sampler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lenet_sampler_pkg
//  Purpose  : Shared FSM state type and size constants for the LeNet frame
//             sampler (crop + box-average of the OV7670 luma stream).
//  Revision : 1.0 - initial release
// ============================================================================
package lenet_sampler_pkg;

  // Default geometry: 640x480 sensor, centred 448x448 crop, 16x16 cells
  localparam int DEF_IMG_W   = 640;
  localparam int DEF_IMG_H   = 480;
  localparam int DEF_X_OFF   = 96;
  localparam int DEF_Y_OFF   = 16;
  localparam int DEF_CELL    = 16;
  localparam int DEF_OUT_DIM = 28;

  // Sizes derived from the default geometry
  localparam int CELL_LOG2 = $clog2(DEF_CELL);
  localparam int ACC_W     = 8 + 2 * CELL_LOG2;
  localparam int BUF_DEPTH = DEF_OUT_DIM * DEF_OUT_DIM;
  localparam int ADDR_W    = $clog2(BUF_DEPTH);

  // Encoding is visible on state_dbg, so values are pinned explicitly
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_READY     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lenet_sample_ram.sv
`default_nettype none
// ============================================================================
//  Module   : lenet_sample_ram
//  Purpose  : DEPTH x 8 sample buffer, one write port and one registered read
//             port. Out-of-range read addresses return 0.
//  Revision : 1.0 - initial release
// ============================================================================
module lenet_sample_ram
  import lenet_sampler_pkg::*;
#(
  parameter int DEPTH  = BUF_DEPTH,
  parameter int RD_AW  = ADDR_W,
  localparam int MEM_AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [MEM_AW-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [RD_AW-1:0]  rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read mux with range guard so addresses beyond the image read as zero
  always_comb begin
    rd_data_d = '0;
    if (32'(rd_addr) < 32'(DEPTH)) rd_data_d = mem_q[rd_addr[MEM_AW-1:0]];
  end

  // Registered read output, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/lenet_frame_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : lenet_frame_sampler
//  Purpose  : Crops a centred window from the luma stream, box-averages it to
//             OUT_DIM x OUT_DIM pixels, and hands the image to LeNet with a
//             data_ready / lenet_go / lenet_ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module lenet_frame_sampler
  import lenet_sampler_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int X_OFF   = DEF_X_OFF,
  parameter int Y_OFF   = DEF_Y_OFF,
  parameter int CELL    = DEF_CELL,
  parameter int OUT_DIM = DEF_OUT_DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              lenet_go,
  input  logic              lenet_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              data_ready,
  output logic [2:0]        state_dbg
);

  localparam int CL     = $clog2(CELL);
  localparam int AW     = 8 + 2 * CL;        // accumulator width
  localparam int CROP   = OUT_DIM * CELL;
  localparam int DEPTH  = OUT_DIM * OUT_DIM;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int X_W    = $clog2(IMG_W);
  localparam int Y_W    = $clog2(IMG_H + 1); // y saturates at IMG_H
  localparam int CX_W   = $clog2(OUT_DIM);
  localparam int D_W    = CX_W + CL;         // crop-relative coordinate width

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [AW-1:0]  acc_q [OUT_DIM];
  logic [AW-1:0]  acc_d [OUT_DIM];

  logic [D_W-1:0]    dx, dy;
  logic [CX_W-1:0]   cx, cy;
  logic [CL-1:0]     ox, oy;
  logic              in_crop, cell_first, cell_last, last_cell;
  logic [AW-1:0]     acc_sum;
  logic              wr_en;
  logic [MEM_AW-1:0] wr_addr;
  logic [7:0]        wr_data;

  // Crop test and cell/offset decomposition of the current pixel position
  always_comb begin
    in_crop = (32'(x_q) >= 32'(X_OFF)) && (32'(x_q) < 32'(X_OFF + CROP)) &&
              (32'(y_q) >= 32'(Y_OFF)) && (32'(y_q) < 32'(Y_OFF + CROP));
    dx         = D_W'(32'(x_q) - 32'(X_OFF));
    dy         = D_W'(32'(y_q) - 32'(Y_OFF));
    cx         = dx[D_W-1:CL];
    cy         = dy[D_W-1:CL];
    ox         = dx[CL-1:0];
    oy         = dy[CL-1:0];
    cell_first = (ox == '0) && (oy == '0);
    cell_last  = (&ox) && (&oy);
    last_cell  = (cx == CX_W'(OUT_DIM - 1)) && (cy == CX_W'(OUT_DIM - 1));
    // Cannot overflow: at most CELL*CELL samples of 255 fit in AW bits
    acc_sum    = acc_q[cx] + AW'(pix_data);
  end

  // Next-state, counter, accumulator and buffer-write logic
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      ST_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (frame_start) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (frame_start) begin
          // Restart abandons the partial image; cells are re-seeded anyway
          x_d = '0;
          y_d = '0;
        end else if (pix_valid) begin
          if (x_q == X_W'(IMG_W - 1)) begin
            x_d = '0;
            if (y_q != Y_W'(IMG_H)) y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
          if (in_crop) begin
            if (cell_first) acc_d[cx] = AW'(pix_data);
            else            acc_d[cx] = acc_sum;
            if (cell_last) begin
              wr_en   = 1'b1;
              wr_addr = MEM_AW'(32'(cy) * 32'(OUT_DIM) + 32'(cx));
              wr_data = acc_sum[AW-1 -: 8];  // truncating divide by CELL*CELL
              if (last_cell) state_d = ST_READY;
            end
          end
        end
      end
      ST_READY:     if (lenet_go)     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!lenet_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (lenet_ready)  state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // State, counter and accumulator registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      for (int i = 0; i < OUT_DIM; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
    end
  end

  lenet_sample_ram #(
    .DEPTH (DEPTH),
    .RD_AW (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign data_ready = (state_q == ST_READY);
  assign state_dbg  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_lenet_frame_sampler.sv
`timescale 1ns/1ps
module tb_lenet_frame_sampler;

  // Reduced geometry keeps each frame to about 2k cycles
  localparam int IMG_W   = 48;
  localparam int IMG_H   = 40;
  localparam int X_OFF   = 8;
  localparam int Y_OFF   = 4;
  localparam int CELL    = 4;
  localparam int OUT_DIM = 8;
  localparam int CROP    = OUT_DIM * CELL;
  localparam int DEPTH   = OUT_DIM * OUT_DIM;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'd0;
  logic       lenet_go = 1'b0;
  logic       lenet_ready = 1'b1;
  logic [9:0] rd_addr = 10'd0;
  wire  [7:0] rd_data;
  wire        data_ready;
  wire  [2:0] state_dbg;

  always #5 clk = ~clk;

  lenet_frame_sampler #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
    .CELL(CELL), .OUT_DIM(OUT_DIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .lenet_go(lenet_go), .lenet_ready(lenet_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .data_ready(data_ready),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dr_rises = 0;
  logic dr_prev = 1'b0;

  logic [7:0] img [IMG_H][IMG_W];
  int         exp_buf [DEPTH];

  typedef struct {
    int         cycles;
    logic       fs, go, lr;
    logic [2:0] st;
    logic       dr;
  } hs_t;
  hs_t hs [8];

  // Count rising edges of data_ready
  always @(negedge clk) begin
    if (data_ready === 1'b1 && dr_prev === 1'b0) dr_rises++;
    dr_prev = data_ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: each output pixel is floor(mean of its CELLxCELL crop block)
  task automatic build_expected();
    for (int cy = 0; cy < OUT_DIM; cy++)
      for (int cx = 0; cx < OUT_DIM; cx++) begin
        int s = 0;
        for (int i = 0; i < CELL; i++)
          for (int j = 0; j < CELL; j++)
            s += int'(img[Y_OFF + cy*CELL + i][X_OFF + cx*CELL + j]);
        exp_buf[cy*OUT_DIM + cx] = s / (CELL*CELL);
      end
  endtask

  // kind 0: uniform val; 1: column stripes with a sub-unit excess; 2: random
  task automatic fill(input int kind, input int val);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) begin
        int in_c = (x >= X_OFF && x < X_OFF + CROP && y >= Y_OFF && y < Y_OFF + CROP);
        case (kind)
          0: img[y][x] = 8'(val);
          1: if (in_c != 0) begin
               int c = (x - X_OFF) / CELL;
               int ex = (((x - X_OFF) % CELL) == CELL-1 && ((y - Y_OFF) % CELL) < 3) ? 1 : 0;
               img[y][x] = 8'(c + ex);    // 3/16 extra must truncate away
             end else img[y][x] = 8'($urandom_range(255));
          default: img[y][x] = 8'($urandom_range(255));
        endcase
      end
    build_expected();
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic drive_pixels(input int y0, input int y1, input int gap_pct, input logic expect_done);
    for (int y = y0; y < y1; y++)
      for (int x = 0; x < IMG_W; x++) begin
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
          pix_valid = 1'b0;
          step();
        end
        pix_valid = 1'b1;
        pix_data  = img[y][x];
        step();
        if (y == Y_OFF + CROP - 1 && x == X_OFF + CROP - 2)
          check("dr_before_last_pixel", 32'(data_ready), 0);
        if (y == Y_OFF + CROP - 1 && x == X_OFF + CROP - 1)
          check("dr_after_last_pixel", 32'(data_ready), 32'(expect_done));
      end
    pix_valid = 1'b0;
  endtask

  // mode 0: compare to model; mode 1: stripe image, entry equals its column
  task automatic read_all(input string name, input int mode);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 10'(a);
      step();
      check(name, 32'(rd_data), (mode == 0) ? 32'(exp_buf[a]) : 32'(a % OUT_DIM));
    end
  endtask

  task automatic release_image();
    lenet_go = 1'b1;
    step();
    lenet_go = 1'b0;
    lenet_ready = 1'b0;
    step();
    lenet_ready = 1'b1;
    step();
    check("release_to_idle", 32'(state_dbg), 0);
  endtask

  initial begin
    int r0;
    hs[0] = '{3,   1'b0, 1'b0, 1'b1, 3'd2, 1'b1};  // READY holds
    hs[1] = '{1,   1'b0, 1'b1, 1'b1, 3'd3, 1'b0};  // go -> WAIT_BUSY, dr falls
    hs[2] = '{1,   1'b0, 1'b0, 1'b1, 3'd3, 1'b0};  // ready still high
    hs[3] = '{1,   1'b0, 1'b0, 1'b0, 3'd4, 1'b0};  // LeNet busy
    hs[4] = '{1,   1'b1, 1'b0, 1'b0, 3'd4, 1'b0};  // frame_start dropped
    hs[5] = '{98,  1'b0, 1'b0, 1'b0, 3'd4, 1'b0};
    hs[6] = '{1,   1'b0, 1'b0, 1'b1, 3'd0, 1'b0};  // done -> IDLE
    hs[7] = '{1,   1'b1, 1'b0, 1'b1, 3'd1, 1'b0};  // next frame accepted

    // Reset state
    rst_n = 1'b0;
    step(); step(); step();
    check("reset_state", 32'(state_dbg), 0);
    check("reset_data_ready", 32'(data_ready), 0);
    check("reset_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    step();

    // Uniform frame, continuous pixels
    fill(0, 8'h80);
    pulse_fs();
    check("capture_state", 32'(state_dbg), 1);
    drive_pixels(0, IMG_H, 0, 1'b1);
    check("ready_state", 32'(state_dbg), 2);
    read_all("uniform_buf", 0);
    rd_addr = 10'(DEPTH);
    step();
    check("oob_read_depth", 32'(rd_data), 0);
    rd_addr = 10'd1023;
    step();
    check("oob_read_max", 32'(rd_data), 0);

    // Handshake sequence
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < hs[i].cycles; c++) begin
        frame_start = hs[i].fs;
        lenet_go    = hs[i].go;
        lenet_ready = hs[i].lr;
        step();
        check("hs_state", 32'(state_dbg), 32'(hs[i].st));
        check("hs_data_ready", 32'(data_ready), 32'(hs[i].dr));
      end
    frame_start = 1'b0;
    lenet_go    = 1'b0;
    lenet_ready = 1'b1;

    // Stripe frame (restart from CAPTURE)
    fill(1, 0);
    pulse_fs();
    drive_pixels(0, IMG_H, 0, 1'b1);
    read_all("stripe_buf", 1);
    release_image();

    // Restart mid-frame: first frame 0xFF abandoned at y=20
    fill(0, 8'hFF);
    pulse_fs();
    drive_pixels(0, 20, 0, 1'b0);
    r0 = dr_rises;
    fill(0, 8'h10);
    pulse_fs();
    drive_pixels(0, IMG_H, 0, 1'b1);
    check("restart_single_rise", 32'(dr_rises - r0), 1);
    read_all("restart_buf", 0);
    release_image();

    // Uniform frame with 50% pix_valid gaps
    fill(0, 8'h80);
    pulse_fs();
    drive_pixels(0, IMG_H, 50, 1'b1);
    read_all("gap_uniform_buf", 0);
    release_image();

    // Random image, random gaps
    fill(2, 0);
    pulse_fs();
    drive_pixels(0, IMG_H, 30, 1'b1);
    read_all("random_buf", 0);
    release_image();

    // Reset mid-capture
    fill(0, 8'h80);
    pulse_fs();
    drive_pixels(0, 20, 0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_data_ready", 32'(data_ready), 0);
    check("midrst_state", 32'(state_dbg), 0);
    r0 = dr_rises;
    drive_pixels(20, IMG_H, 0, 1'b0);
    check("midrst_no_rise", 32'(dr_rises - r0), 0);
    check("midrst_still_idle", 32'(state_dbg), 0);
    fill(0, 8'h3C);
    pulse_fs();
    drive_pixels(0, IMG_H, 0, 1'b1);
    read_all("post_reset_buf", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lenet_frame_sampler.md
Name: lenet_frame_sampler

Overview:
- Upstream feeder of the LeNet start controller.
- Takes the OV7670 luma pixel stream, crops a centred 448x448 window and box-averages it to 28x28 8-bit pixels in a local buffer.
- Raises data_ready when the image is complete, then holds the buffer stable until LeNet has consumed it.
- LeNet reads the buffer through a synchronous read port.

Parameters:
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- X_OFF, 96, first cropped column
- Y_OFF, 16, first cropped line
- CELL, 16, averaging cell edge in pixels; must be a power of 2
- OUT_DIM, 28, output image edge; crop edge = OUT_DIM*CELL

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse before the first pixel of a frame
- pix_valid  in  1  pix_data is valid this cycle (raster order)
- pix_data  in  8  luma sample
- lenet_go  in  1  one-cycle start pulse from the LeNet controller
- lenet_ready  in  1  LeNet idle (high) / running (low)
- rd_addr  in  10  LeNet read address, row-major (y*OUT_DIM+x)
- rd_data  out  8  buffer word, registered
- data_ready  out  1  complete image available, not yet taken
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset: the interface is one clock, synchronous active-low reset, clk/rst_n.
  - Reset forces the FSM to IDLE and clears data_ready, rd_data, state_dbg and all counters to 0.
  - Buffer contents are undefined after reset.
  - Reset mid-capture discards the partial image.
- FSM states: IDLE=0, CAPTURE=1, READY=2, WAIT_BUSY=3, WAIT_DONE=4.
  - IDLE: on frame_start go to CAPTURE. Pixel counters x,y are cleared.
  - CAPTURE: each pix_valid advances x. At x=IMG_W-1, x wraps to 0 and y increments. Pixels beyond IMG_H lines are ignored.
  - frame_start in CAPTURE restarts: counters are cleared and the partial image is abandoned.
  - READY: data_ready=1. On lenet_go go to WAIT_BUSY; data_ready falls the cycle after lenet_go.
  - WAIT_BUSY: wait for lenet_ready==0.
  - WAIT_DONE: wait for lenet_ready==1, then go to IDLE. The next frame_start is then accepted.
  - frame_start in READY/WAIT_* is ignored; the frame is dropped.
- Cropping: a pixel is inside the crop when X_OFF<=x<X_OFF+OUT_DIM*CELL and Y_OFF<=y<Y_OFF+OUT_DIM*CELL.
  - Cell coordinates: cx=(x-X_OFF)>>log2(CELL), cy likewise; in-cell offsets are the low log2(CELL) bits.
- Accumulation:
  - One accumulator per output column: OUT_DIM entries, width 8+2*log2(CELL) = 16 bits.
  - First pixel of a cell (both offsets 0): acc[cx] <= pix_data.
  - Other in-crop pixels: acc[cx] <= acc[cx]+pix_data.
  - No overflow is possible by construction.
- Write-back:
  - On the last pixel of a cell (both offsets CELL-1), write buf[cy*OUT_DIM+cx] <= (acc[cx]+pix_data)>>(2*log2(CELL)).
  - The shift truncates; there is no rounding. Write occurs at the next edge.
- Completion: the write of cell (OUT_DIM-1,OUT_DIM-1) also moves the FSM to READY, so data_ready is high the cycle after the last crop pixel. The remaining pixels of that frame are ignored.
- Read port: rd_data <= buf[rd_addr] every cycle in every state, 1-cycle latency.
  - Addresses >= OUT_DIM*OUT_DIM return 0.
  - The buffer is written only in CAPTURE, so reads during READY/WAIT_* are stable.
- pix_valid gaps are allowed anywhere; counters hold while pix_valid is low.

Decomposition:
- Package lenet_sampler_pkg:
  - state enum
  - clog2-derived constants CELL_LOG2, ACC_W, BUF_DEPTH, ADDR_W
- One sub-module, lenet_sample_ram: single write port and single registered read port, BUF_DEPTH x 8, inferable as BRAM.
- FSM, counters and accumulators stay in lenet_frame_sampler.

Test Plan:
- Uniform frame, pix_data=0x80 everywhere, continuous pix_valid -> all 784 entries read 0x80; data_ready rises one cycle after pixel (x=543,y=463).
- Stripe frame, pix_data=(x-X_OFF)>>4 inside the crop -> buf[y*28+x] == x for all rows; checks cell indexing and truncation (7 consecutive values 17,18 averaging to 17).
- Handshake: in READY, pulse lenet_go; hold lenet_ready=1 for 2 cycles, then 0 for 100, then 1 -> data_ready low the cycle after go. A frame_start during the busy phase is dropped. The next frame_start after lenet_ready returns high enters CAPTURE (state_dbg=1).
- Restart: second frame_start at y=200 of a frame whose crop holds 0xFF, second frame all 0x10 -> final buffer all 0x10, single data_ready rise.
- Random pix_valid gaps (50% duty) on the uniform 0x80 frame -> identical buffer to the gapless run.
- rst_n low for 1 cycle mid-capture -> data_ready=0, state_dbg=0. No data_ready until a new full frame after frame_start.
